// File: rtl/subcells_lane_engine_pkg.sv
// Shared constants for the lane-serialised S-box layer: cell width, the
// 4-bit involutive S-box table and the engine state encoding.
package subcells_pkg;

  localparam int CELL_W = 4;

  // Entry k is the substitute for cell value k.
  localparam logic [0:15][CELL_W-1:0] SBOX = {
    4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
    4'h9, 4'h8, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subcells_lane_engine_sbox4.sv
// Combinational 4-bit S-box lookup; one instance per lane.
module sbox4
  import subcells_pkg::*;
(
  input  logic [CELL_W-1:0] a,
  output logic [CELL_W-1:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/subcells_lane_engine.sv
// Lane-serialised S-box substitution over a ROWS x COLS cell matrix:
// LANES cells per cycle in row-major order, result held until accepted.
module subcells_lane_engine
  import subcells_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LANES = 4
) (
  input  logic                                      clock,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [0:ROWS-1][0:COLS-1][CELL_W-1:0]     in_matrix,
  input  logic [ROWS*COLS-1:0]                      cell_mask,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [0:ROWS-1][0:COLS-1][CELL_W-1:0]     out_matrix,
  output logic                                      busy
);

  localparam int NC = ROWS * COLS;
  localparam int N  = NC / LANES;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  if ((NC % LANES) != 0) begin : g_bad_lanes
    $error("subcells_lane_engine: LANES must divide ROWS*COLS");
  end

  // Flat row-major view: element i is cell (i / COLS, i % COLS).
  typedef logic [0:NC-1][CELL_W-1:0] cells_t;

  state_e               state_q, state_d;
  cells_t               work_q, work_d;
  logic [NC-1:0]        mask_q, mask_d;
  logic [GW-1:0]        grp_q, grp_d;
  logic                 busy_q, busy_d;

  logic [LANES-1:0][CELL_W-1:0] lane_in, lane_out;
  logic [LANES-1:0][IW-1:0]     lane_idx;

  always_comb begin
    lane_idx = '0;
    lane_in  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = IW'(int'(grp_q) * LANES + l);
      lane_in[l]  = work_q[lane_idx[l]];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox4 u_sbox (
      .a (lane_in[g]),
      .y (lane_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mask_d  = mask_q;
    grp_d   = grp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = cells_t'(in_matrix);
          mask_d  = cell_mask;
          grp_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          if (mask_q[lane_idx[l]]) work_d[lane_idx[l]] = lane_out[l];
        end
        if (grp_q == GW'(N - 1)) begin
          grp_d   = '0;
          state_d = DONE;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      mask_q  <= '0;
      grp_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      grp_q   <= grp_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_matrix = work_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_subcells_lane_engine.sv
// Directed bench: three engines (LANES = 4, 1, 16) on a 4x4 matrix, driven
// from a vector table plus hand-written backpressure and reset sequences.
module tb_subcells_lane_engine;

  localparam logic [63:0] ID_M = 64'h0123456789ABCDEF;
  localparam logic [63:0] SB_M = 64'hCAD3EBF798150246;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  iv = '0, ordy = '0, ir, ov, bz;
  logic [63:0] imat = '0;
  logic [15:0] imask = '0;
  logic [63:0] om [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subcells_lane_engine #(.ROWS(4), .COLS(4), .LANES(4)) u_l4 (
    .clock(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_matrix(imat),
    .cell_mask(imask), .out_valid(ov[0]), .out_ready(ordy[0]), .out_matrix(om[0]), .busy(bz[0]));
  subcells_lane_engine #(.ROWS(4), .COLS(4), .LANES(1)) u_l1 (
    .clock(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_matrix(imat),
    .cell_mask(imask), .out_valid(ov[1]), .out_ready(ordy[1]), .out_matrix(om[1]), .busy(bz[1]));
  subcells_lane_engine #(.ROWS(4), .COLS(4), .LANES(16)) u_l16 (
    .clock(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_matrix(imat),
    .cell_mask(imask), .out_valid(ov[2]), .out_ready(ordy[2]), .out_matrix(om[2]), .busy(bz[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One full transaction on engine k; inputs are scrambled right after
  // acceptance so the result must come from the captured values only.
  task automatic run_op(input int k, input logic [63:0] m, input logic [15:0] msk,
                        input logic [63:0] exp, input int lat, input bit early);
    int n;
    n = 0;
    while (!ir[k] && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("ready_before[%0d]", k), 64'(ir[k]), 64'd1);
    imat = m; imask = msk; iv[k] = 1'b1; ordy[k] = early;
    @(negedge clk);
    iv[k] = 1'b0; imat = ~m; imask = ~msk;
    chk($sformatf("busy_run[%0d]", k), 64'(bz[k]), 64'd1);
    chk($sformatf("ready_run[%0d]", k), 64'(ir[k]), 64'd0);
    n = 0;
    while (!ov[k] && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("latency[%0d]", k), 64'(n), 64'(lat));
    chk($sformatf("result[%0d]", k), om[k], exp);
    chk($sformatf("busy_done[%0d]", k), 64'(bz[k]), 64'd0);
    ordy[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("valid_after[%0d]", k), 64'(ov[k]), 64'd0);
    chk($sformatf("ready_after[%0d]", k), 64'(ir[k]), 64'd1);
    ordy[k] = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [63:0] m;
    logic [15:0] msk;
    logic [63:0] exp;
    int          lat;
    bit          early;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, ID_M, 16'hFFFF, SB_M, 4, 1'b0};
    vt[1] = '{0, SB_M, 16'hFFFF, ID_M, 4, 1'b1};
    vt[2] = '{1, ID_M, 16'hFFFF, SB_M, 16, 1'b0};
    vt[3] = '{1, SB_M, 16'hFFFF, ID_M, 16, 1'b1};
    vt[4] = '{2, ID_M, 16'hFFFF, SB_M, 1, 1'b0};
    vt[5] = '{2, SB_M, 16'hFFFF, ID_M, 1, 1'b1};
    vt[6] = '{0, 64'h1111111111111111, 16'h00FF, 64'hAAAAAAAA11111111, 4, 1'b0};
    vt[7] = '{0, ID_M, 16'h8001, 64'hC123456789ABCDE6, 4, 1'b0};
    vt[8] = '{1, ID_M, 16'h0000, ID_M, 16, 1'b0};

    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 64'(ir[k]), 64'd1);
      chk($sformatf("rst_valid[%0d]", k), 64'(ov[k]), 64'd0);
      chk($sformatf("rst_busy[%0d]", k), 64'(bz[k]), 64'd0);
      chk($sformatf("rst_out[%0d]", k), om[k], 64'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vt[i].k, vt[i].m, vt[i].msk, vt[i].exp, vt[i].lat, vt[i].early);

    // Backpressure: hold DONE for 10 cycles while a second request is offered.
    imat = ID_M; imask = 16'hFFFF; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    for (int n = 0; n < 100 && !ov[0]; n++) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      iv[0] = 1'b1; imat = 64'h5555555555555555;
      @(negedge clk);
      chk("bp_valid", 64'(ov[0]), 64'd1);
      chk("bp_out", om[0], SB_M);
      chk("bp_ready", 64'(ir[0]), 64'd0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(ov[0]), 64'd0);
    chk("bp_release_ready", 64'(ir[0]), 64'd1);
    chk("bp_release_busy", 64'(bz[0]), 64'd0);
    ordy[0] = 1'b0;
    @(negedge clk);

    // Reset in the middle of RUN, then a fresh matrix.
    imat = ID_M; imask = 16'hFFFF; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(ir[0]), 64'd1);
    chk("midrst_valid", 64'(ov[0]), 64'd0);
    chk("midrst_busy", 64'(bz[0]), 64'd0);
    chk("midrst_out", om[0], 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 64'(ov[0]), 64'd0);
    run_op(0, 64'h1111111111111111, 16'h00FF, 64'hAAAAAAAA11111111, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
